key_expand_seq: RTL

//   Sequences the feistel round core through one Blowfish/bcrypt ExpandKey

---
 rtl/key_expand_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/key_expand_seq.sv
// Sequencer for one Blowfish/bcrypt ExpandKey pass: chains 521 feistel
// encryptions and streams each 64-bit result into P, then S1..S4.
module key_expand_seq #(
    parameter int NUM_P     = 18,
    parameter int S_ENTRIES = 256
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         salt_en_i,
    input  logic [127:0] salt_i,
    output logic         f_start_o,
    output logic [31:0]  f_l_o,
    output logic [31:0]  f_r_o,
    input  logic [31:0]  f_result_l_i,
    input  logic [31:0]  f_result_r_i,
    input  logic         f_done_i,
    output logic         wr_en_o,
    output logic [2:0]   wr_sel_o,
    output logic [7:0]   wr_addr_o,
    output logic [31:0]  wr_data_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int NUM_BLK = (NUM_P + 4 * S_ENTRIES) / 2;
    localparam logic [9:0]  LAST_BLK = 10'(NUM_BLK - 1);
    localparam logic [10:0] P_WORDS  = 11'(NUM_P);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_F,
        ST_WR_L,
        ST_WR_R,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cl_q, cl_d;
    logic [31:0] cr_q, cr_d;
    logic [9:0]  k_q, k_d;
    logic        salt_en_q, salt_en_d;
    logic [31:0] f_l_q, f_l_d;
    logic [31:0] f_r_q, f_r_d;

    // Salt split into four words, most significant first
    logic [31:0] salt_w [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_salt
            assign salt_w[gi] = salt_i[127 - 32*gi -: 32];
        end
    endgenerate

    logic [31:0] sw_hi, sw_lo;
    logic [10:0] word;
    logic [9:0]  s_word;

    always_comb begin
        state_d   = state_q;
        cl_d      = cl_q;
        cr_d      = cr_q;
        k_d       = k_q;
        salt_en_d = salt_en_q;
        f_l_d     = 32'd0;
        f_r_d     = 32'd0;
        sw_hi     = 32'd0;
        sw_lo     = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    salt_en_d = salt_en_i;
                    cl_d      = 32'd0;
                    cr_d      = 32'd0;
                    k_d       = 10'd0;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT_F;
            ST_WAIT_F: begin
                if (f_done_i) begin
                    cl_d    = f_result_l_i;
                    cr_d    = f_result_r_i;
                    state_d = ST_WR_L;
                end
            end
            ST_WR_L: state_d = ST_WR_R;
            ST_WR_R: begin
                if (k_q == LAST_BLK) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 10'd1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Block operands are formed from the values the block will launch with
        if (salt_en_d) begin
            sw_hi = salt_w[{k_d[0], 1'b0}];
            sw_lo = salt_w[{k_d[0], 1'b1}];
        end
        if (state_d == ST_LAUNCH) begin
            f_l_d = cl_d ^ sw_hi;
            f_r_d = cr_d ^ sw_lo;
        end else if (state_d == ST_WAIT_F) begin
            f_l_d = f_l_q;
            f_r_d = f_r_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cl_q      <= 32'd0;
            cr_q      <= 32'd0;
            k_q       <= 10'd0;
            salt_en_q <= 1'b0;
            f_l_q     <= 32'd0;
            f_r_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cl_q      <= cl_d;
            cr_q      <= cr_d;
            k_q       <= k_d;
            salt_en_q <= salt_en_d;
            f_l_q     <= f_l_d;
            f_r_q     <= f_r_d;
        end
    end

    // Word index 2k / 2k+1; S-box words are offset past the P array
    assign word   = {k_q, (state_q == ST_WR_R)};
    assign s_word = word[9:0] - P_WORDS[9:0];

    always_comb begin
        f_start_o = (state_q == ST_LAUNCH);
        f_l_o     = f_l_q;
        f_r_o     = f_r_q;
        busy_o    = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_F) ||
                    (state_q == ST_WR_L)   || (state_q == ST_WR_R);
        done_o    = (state_q == ST_DONE);
        wr_en_o   = 1'b0;
        wr_sel_o  = 3'd0;
        wr_addr_o = 8'd0;
        wr_data_o = 32'd0;
        if ((state_q == ST_WR_L) || (state_q == ST_WR_R)) begin
            wr_en_o   = 1'b1;
            wr_data_o = (state_q == ST_WR_L) ? cl_q : cr_q;
            if (word < P_WORDS) begin
                wr_addr_o = word[7:0];
            end else begin
                wr_sel_o  = {1'b0, s_word[9:8]} + 3'd1;
                wr_addr_o = s_word[7:0];
            end
        end
    end

endmodule
